// File: rtl/line_follower_pkg.sv
// Shared types for the line-follower command path: opcodes, dispatcher states
// and the station-ID width.
package line_follower_pkg;

    localparam int ID_W = 6;

    typedef enum logic [1:0] {
        OP_STOP = 2'b00,
        OP_GO   = 2'b01
    } opcode_t;

    typedef enum logic {
        IDLE,
        TRANSIT
    } disp_state_t;

endpackage

// File: rtl/cmd_watchdog.sv
// Clearable up-counter that flags expiry on its last allowed cycle and
// saturates there rather than wrapping.
module cmd_watchdog #(
    parameter int LIMIT = 50_000_000,
    parameter int CNT_W = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign expire = en && (count_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher: consumes UART bytes and station-ID reads, tracks the
// destination and drives in_transit, with a watchdog that aborts a stalled transit.
module cmd_dispatch
    import line_follower_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int CNT_W          = 26
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_rdy,
    input  logic [7:0]      cmd,
    output logic            clr_cmd_rdy,
    input  logic            ID_vld,
    input  logic [7:0]      ID,
    output logic            clr_ID_vld,
    output logic            in_transit,
    output logic [ID_W-1:0] dest_id,
    output logic            fault
);

    disp_state_t     state_q, state_d;
    logic            in_transit_q, in_transit_d;
    logic [ID_W-1:0] dest_id_q, dest_id_d;
    logic            fault_q, fault_d;

    logic wd_clr;
    logic wd_en;
    logic wd_expire;

    logic go_cmd;
    logic stop_cmd;
    logic id_hit;

    // Both sources are consumed in every state, so each ack is simply its level,
    // suppressed while reset is held.
    assign clr_cmd_rdy = cmd_rdy & rst_n;
    assign clr_ID_vld  = ID_vld & rst_n;

    assign go_cmd   = cmd_rdy && (cmd[7:6] == OP_GO);
    assign stop_cmd = cmd_rdy && (cmd[7:6] == OP_STOP);
    assign id_hit   = ID_vld && (ID[7:6] == 2'b00) && (ID[ID_W-1:0] == dest_id_q);
    assign wd_en    = (state_q == TRANSIT);

    always_comb begin
        state_d      = state_q;
        in_transit_d = in_transit_q;
        dest_id_d    = dest_id_q;
        fault_d      = fault_q;
        wd_clr       = 1'b0;

        case (state_q)
            IDLE: begin
                wd_clr = 1'b1;
                if (go_cmd) begin
                    state_d      = TRANSIT;
                    in_transit_d = 1'b1;
                    dest_id_d    = cmd[ID_W-1:0];
                    fault_d      = 1'b0;
                end
            end
            TRANSIT: begin
                // Any ID arrival kicks the watchdog, matching or not.
                wd_clr = ID_vld;
                if (stop_cmd) begin
                    state_d      = IDLE;
                    in_transit_d = 1'b0;
                    wd_clr       = 1'b1;
                end else if (go_cmd) begin
                    dest_id_d = cmd[ID_W-1:0];
                    wd_clr    = 1'b1;
                end else if (id_hit) begin
                    state_d      = IDLE;
                    in_transit_d = 1'b0;
                    wd_clr       = 1'b1;
                end else if (wd_expire && !ID_vld) begin
                    state_d      = IDLE;
                    in_transit_d = 1'b0;
                    fault_d      = 1'b1;
                    wd_clr       = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                in_transit_d = 1'b0;
            end
        endcase
    end

    cmd_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_transit_q <= 1'b0;
            dest_id_q    <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_transit_q <= in_transit_d;
            dest_id_q    <= dest_id_d;
            fault_q      <= fault_d;
        end
    end

    assign in_transit = in_transit_q;
    assign dest_id    = dest_id_q;
    assign fault      = fault_q;

endmodule

// File: doc/cmd_dispatch.md
Name: cmd_dispatch

Overview:
- Command controller between the UART receiver (cmd/rdy/clr_rdy) and the line-follower motion logic.
- Consumes each received byte exactly once, decodes GO/STOP opcodes, and holds the destination station.
- Matches incoming station-ID reads against the destination and drives in_transit for the motion controller.
- Includes a watchdog that aborts transit if no station ID arrives within a bounded time.

Parameters:
- TIMEOUT_CYCLES, 50_000_000, clock cycles allowed between successive ID_vld pulses while in transit (1 s at 50 MHz); bench overrides small.
- CNT_W, 26, watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_rdy  in  1  byte available from UART receiver; level, held until cleared
- cmd  in  8  received byte: [7:6] opcode, [5:0] station ID
- clr_cmd_rdy  out  1  one-cycle acknowledge to UART receiver clr_rdy
- ID_vld  in  1  station-ID reader has a valid ID; level, held until cleared
- ID  in  8  station ID read; [7:6] must be 2'b00 to be valid
- clr_ID_vld  out  1  one-cycle acknowledge to ID reader
- in_transit  out  1  motion enable to motion controller
- dest_id  out  6  currently latched destination
- fault  out  1  sticky watchdog-timeout flag

Behaviour:
- Reset, asynchronous: state=IDLE, in_transit=0, dest_id=0, fault=0, watchdog=0. clr_cmd_rdy and clr_ID_vld are 0 while rst_n is low.
- Opcodes: 2'b01 GO(dest=cmd[5:0]); 2'b00 STOP; 2'b10/2'b11 ignored but still acknowledged.
- clr_cmd_rdy and clr_ID_vld are combinational (Mealy) pulses. Each is asserted in the same cycle its level input is seen high in a state that consumes it. The source drops its level on the next edge, so each byte/ID is consumed exactly once, with zero-cycle ack latency.
- Registered outputs (in_transit, dest_id, fault) update on the clock edge where the ack is asserted.
- FSM state IDLE:
  - cmd_rdy & GO: ack; dest_id<=cmd[5:0]; in_transit<=1; fault<=0; watchdog<=0; -> TRANSIT.
  - cmd_rdy & STOP or ignored opcode: ack; stay.
  - ID_vld: ack and discard; stay.
- FSM state TRANSIT:
  - watchdog increments every cycle.
  - cmd_rdy & STOP: ack; in_transit<=0; -> IDLE.
  - cmd_rdy & GO: ack; retarget dest_id<=cmd[5:0]; watchdog<=0; stay.
  - ID_vld: ack; watchdog<=0. If ID[7:6]==0 && ID[5:0]==dest_id: in_transit<=0, -> IDLE. Otherwise stay.
  - watchdog == TIMEOUT_CYCLES-1 with no ID_vld that cycle: fault<=1, in_transit<=0, -> IDLE.
- Simultaneous events in TRANSIT: both acks pulse in the same cycle. Precedence for state and registers is cmd (STOP/GO) > ID match > watchdog timeout. Example: GO retarget plus an ID equal to the old dest stays in TRANSIT with the new dest.
- Watchdog:
  - Saturates/clears only as listed above and never wraps.
  - Held at 0 in IDLE.
  - A valid ID that arrives in the timeout cycle counts as an arrival and suppresses the fault.
- fault is cleared only by the next accepted GO or by reset.
- Reset mid-transit returns to IDLE immediately. No ack pulse is issued during reset; any pending byte is consumed after reset.

Decomposition:
- Shared package line_follower_pkg:
  - typedef enum logic[1:0] opcode_t {OP_STOP=2'b00, OP_GO=2'b01}
  - typedef enum logic {IDLE, TRANSIT} disp_state_t
  - localparam ID_W=6
- Sub-module: none required. Optionally isolate the watchdog as cmd_watchdog (counter, clear, enable, expire), reusable for other timeout needs.

Test Plan:
- Reset with cmd_rdy=1, cmd=8'h45 held -> no clr_cmd_rdy while rst_n=0. First cycle after release: clr_cmd_rdy=1 for exactly one cycle; next edge in_transit=1, dest_id=6'h05.
- In TRANSIT dest 6'h05, ID_vld with ID=8'h03 then 8'h05 -> clr_ID_vld pulses once per ID. in_transit stays 1 after 8'h03 and drops to 0 on the edge accepting 8'h05.
- In TRANSIT, byte 8'h00 (STOP) -> one clr_cmd_rdy; in_transit=0; dest_id unchanged at 6'h05.
- TIMEOUT_CYCLES=20, GO 8'h4A, no ID -> fault=1 and in_transit=0 exactly 20 cycles after entering TRANSIT. A subsequent GO 8'h41 clears fault and sets dest_id=6'h01.
- Same cycle: cmd=8'h47 (GO 7) and ID=8'h05 with dest 5 -> both acks pulse; remains TRANSIT with dest_id=6'h07.
- Bytes 8'h85 and 8'hC5 in IDLE -> each acknowledged once; in_transit stays 0; dest_id unchanged.
